// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package fetch_pkg;

  // One buffered instruction together with the address it was fetched from.
  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } fetch_entry_t;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  // Width of a counter that must hold 0..depth inclusive.
  function automatic int cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of fetch entries with push/pop/flush and occupancy count.
// Latency: a pushed entry appears at the head the cycle after the push.
// Backpressure: none internally; the caller guarantees no push when full, pop when empty is ignored.
//
// Ports: clk, rst (async active-high), flush, push/din, pop, head (valid when count != 0), count.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int CW = cnt_width(DEPTH)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         push,
  input  fetch_entry_t din,
  input  logic         pop,
  output fetch_entry_t head,
  output logic [CW-1:0] count
);

  localparam int AW = $clog2(DEPTH);

  fetch_entry_t  mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [CW-1:0] cnt;
  logic          do_push;
  logic          do_pop;

  // Flush dominates both push and pop in the same cycle.
  assign do_push = push && !flush;
  assign do_pop  = pop && (cnt != '0) && !flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      cnt <= cnt + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage needs no reset: contents are only observed through count.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  assign head  = mem[rd_ptr];
  assign count = cnt;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: PC, credit-limited in-order imem reads, instruction buffer, redirect flush.
// Latency: response visible on instr_* the cycle after imem_rvalid (no bypass).
// Backpressure: requests stop when outstanding + buffered reaches FIFO_DEPTH; decode stalls via instr_ready.
//
// Ports: clk, rst (async active-high); imem_req/imem_addr/imem_ready request side;
// imem_rvalid/imem_rdata in-order responses; redirect/redirect_target from decode;
// instr_valid/instr_ready/instr/instr_pc/instr_pc_plus4 towards decode.
// Optional macro FETCH_MISALIGN_TRAP_EN: adds instr_fault; a misaligned redirect presents
// one faulting NOP at the target and stalls fetch until the next redirect.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_target,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
`ifdef FETCH_MISALIGN_TRAP_EN
  output logic        instr_fault,
`endif
  output logic [31:0] instr_pc_plus4
);

  localparam int CW = cnt_width(FIFO_DEPTH);
  localparam logic [CW:0] DEPTH_C = (CW+1)'(FIFO_DEPTH);

  logic [31:0]   pc;
  logic [31:0]   resp_pc;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] outstanding_nxt;
  logic [CW-1:0] discard;
  logic [CW-1:0] fifo_count;
  logic [CW:0]   in_flight;
  logic          hs;
  logic          push;
  logic          pop;
  logic          fifo_vld;
  logic          stall;
  logic [31:0]   tgt;
  fetch_entry_t  head;
  fetch_entry_t  out_e;

  assign fifo_vld  = (fifo_count != '0);
  assign in_flight = {1'b0, outstanding} + {1'b0, fifo_count};
  assign imem_addr = pc;
  // Credits cover buffered entries too, so every accepted response has a FIFO slot.
  assign imem_req  = !rst && !redirect && !stall && (in_flight < DEPTH_C);
  assign hs        = imem_req && imem_ready;

  // Outstanding count after this cycle's handshake and response; on a redirect all
  // of these are stale, including any already marked for discard.
  assign outstanding_nxt = outstanding + CW'(hs) - CW'(imem_rvalid);

  assign push = imem_rvalid && (discard == '0) && !redirect;

`ifdef FETCH_MISALIGN_TRAP_EN
  logic fault_arm;
  logic fault_vld;

  assign tgt = redirect_target;

  // The fault entry is held back one cycle so the flush cycle still shows an empty stage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall     <= 1'b0;
      fault_arm <= 1'b0;
      fault_vld <= 1'b0;
    end else if (redirect) begin
      stall     <= (redirect_target[1:0] != 2'b00);
      fault_arm <= (redirect_target[1:0] != 2'b00);
      fault_vld <= 1'b0;
    end else begin
      fault_arm <= 1'b0;
      if (fault_arm)                     fault_vld <= 1'b1;
      else if (fault_vld && instr_ready) fault_vld <= 1'b0;
    end
  end

  assign instr_fault = fault_vld;
  assign instr_valid = fault_vld || fifo_vld;
  assign pop         = fifo_vld && !fault_vld && instr_ready && !redirect;

  always_comb begin
    out_e = '0;
    if (fault_vld) begin
      out_e.instr = NOP_INSTR;
      out_e.pc    = pc;
    end else if (fifo_vld) begin
      out_e = head;
    end
  end
`else
  assign stall       = 1'b0;
  assign tgt         = redirect_target & ~32'd3;
  assign instr_valid = fifo_vld;
  assign pop         = fifo_vld && instr_ready && !redirect;

  always_comb begin
    out_e = '0;
    if (fifo_vld) out_e = head;
  end
`endif

  assign instr          = out_e.instr;
  assign instr_pc       = out_e.pc;
  assign instr_pc_plus4 = out_e.pc + 32'd4;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc          <= RESET_PC;
      resp_pc     <= RESET_PC;
      outstanding <= '0;
      discard     <= '0;
    end else begin
      outstanding <= outstanding_nxt;
      if (redirect) begin
        pc      <= tgt;
        resp_pc <= tgt;
        discard <= outstanding_nxt;
      end else begin
        if (hs) pc <= pc + 32'd4;
        if (imem_rvalid) begin
          if (discard != '0) discard <= discard - 1'b1;
          else               resp_pc <= resp_pc + 32'd4;
        end
      end
    end
  end

  fetch_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (redirect),
    .push  (push),
    .din   ('{instr: imem_rdata, pc: resp_pc}),
    .pop   (pop),
    .head  (head),
    .count (fifo_count)
  );

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_target;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic [31:0] instr_pc_plus4;
`ifdef FETCH_MISALIGN_TRAP_EN
  logic        instr_fault;
`endif

  fetch_unit dut (
    .clk             (clk),
    .rst             (rst),
    .imem_req        (imem_req),
    .imem_addr       (imem_addr),
    .imem_ready      (imem_ready),
    .imem_rvalid     (imem_rvalid),
    .imem_rdata      (imem_rdata),
    .redirect        (redirect),
    .redirect_target (redirect_target),
    .instr_valid     (instr_valid),
    .instr_ready     (instr_ready),
    .instr           (instr),
    .instr_pc        (instr_pc),
`ifdef FETCH_MISALIGN_TRAP_EN
    .instr_fault     (instr_fault),
`endif
    .instr_pc_plus4  (instr_pc_plus4)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } req_t;

  // Memory model: in-order pending reads with a ready cycle each.
  req_t        mem_q[$];
  logic [31:0] issued_q[$];
  logic [31:0] consumed_q[$];
  int          cyc;
  int          checks;
  int          errors;
  int          p_mrdy, p_irdy, p_rsp, max_lat;
  bit          mem_hold;
  bit          expect_empty;
  // Program-order reference: next address to fetch and next address decode should see.
  logic [31:0] fetch_pc;
  logic [31:0] exp_pc;

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return {a[15:0] ^ 16'hC3A5, a[31:16]};
  endfunction

  task automatic cycle(input int mode, input logic [31:0] tgt, output bit did_redir);
    req_t r;
    @(negedge clk);
    cyc++;
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
    if (mem_q.size() > 0 && !mem_hold && mem_q[0].due <= cyc && $urandom_range(99) < p_rsp) begin
      r = mem_q.pop_front();
      imem_rvalid = 1'b1;
      imem_rdata  = mem_data(r.addr);
    end
    imem_ready      = ($urandom_range(99) < p_mrdy);
    instr_ready     = ($urandom_range(99) < p_irdy);
    redirect        = 1'b0;
    redirect_target = '0;
    if (mode == 1) begin
      redirect        = 1'b1;
      redirect_target = tgt;
    end
    #1;
    if (mode == 2 && imem_rvalid && instr_valid && instr_ready) begin
      redirect        = 1'b1;
      redirect_target = tgt;
      #1;
    end
    did_redir = redirect;
    if (expect_empty) begin
      checks++;
      if (instr_valid !== 1'b0) begin
        errors++;
        $display("FAIL flush_empty: instr_valid=%b expected 0 (cycle %0d)", instr_valid, cyc);
      end
    end
    expect_empty = 1'b0;
    if (redirect) begin
      checks++;
      if (imem_req !== 1'b0) begin
        errors++;
        $display("FAIL redirect_req: imem_req=%b expected 0 (cycle %0d)", imem_req, cyc);
      end
    end
    if (imem_req === 1'b1) begin
      checks++;
      if (imem_addr !== fetch_pc) begin
        errors++;
        $display("FAIL fetch_addr: imem_addr=%h expected %h (cycle %0d)", imem_addr, fetch_pc, cyc);
      end
      if (imem_ready) begin
        mem_q.push_back('{addr: imem_addr, due: cyc + 1 + int'($urandom_range(max_lat))});
        issued_q.push_back(imem_addr);
        fetch_pc += 32'd4;
      end
    end
    if (instr_valid === 1'b1 && instr_ready && !redirect) begin
      checks++;
      if (instr_pc !== exp_pc || instr !== mem_data(exp_pc) || instr_pc_plus4 !== exp_pc + 32'd4) begin
        errors++;
        $display("FAIL deliver: pc=%h instr=%h pc4=%h expected pc=%h instr=%h pc4=%h (cycle %0d)",
                 instr_pc, instr, instr_pc_plus4, exp_pc, mem_data(exp_pc), exp_pc + 32'd4, cyc);
      end
      consumed_q.push_back(instr_pc);
      exp_pc += 32'd4;
    end
    if (redirect) begin
`ifdef FETCH_MISALIGN_TRAP_EN
      exp_pc = tgt;
`else
      exp_pc = tgt & ~32'd3;
`endif
      fetch_pc     = exp_pc;
      expect_empty = 1'b1;
    end
  endtask

  task automatic run(input int n);
    bit d;
    for (int i = 0; i < n; i++) cycle(0, '0, d);
  endtask

  task automatic set_knobs(input int mrdy, input int irdy, input int rsp, input int lat);
    p_mrdy = mrdy; p_irdy = irdy; p_rsp = rsp; max_lat = lat; mem_hold = 1'b0;
  endtask

  task automatic clear_model();
    mem_q.delete(); issued_q.delete(); consumed_q.delete();
    fetch_pc = 32'h0; exp_pc = 32'h0; expect_empty = 1'b0;
  endtask

  task automatic check_val(input string name, input logic [31:0] got, input logic [31:0] exp);
    // intentionally unused helper removed; see inline checks
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1; imem_ready = 0; imem_rvalid = 0; imem_rdata = 0;
    redirect = 0; redirect_target = 0; instr_ready = 0;
    #1;
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL reset_req: imem_req=%b expected 0", imem_req); end
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: instr_valid=%b expected 0", instr_valid); end
    checks++; if (instr !== 32'h0) begin errors++; $display("FAIL reset_instr: instr=%h expected 0", instr); end
    checks++; if (instr_pc !== 32'h0) begin errors++; $display("FAIL reset_pc: instr_pc=%h expected 0", instr_pc); end
    checks++; if (instr_pc_plus4 !== 32'h4) begin errors++; $display("FAIL reset_pc4: instr_pc_plus4=%h expected 4", instr_pc_plus4); end
    clear_model();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_sequential();
    test_reset();
    set_knobs(100, 100, 100, 0);
    run(12);
    checks++;
    if (issued_q.size() < 3 || consumed_q.size() < 3) begin
      errors++; $display("FAIL seq_count: issued=%0d consumed=%0d expected >=3", issued_q.size(), consumed_q.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (issued_q[i] !== 32'(4 * i) || consumed_q[i] !== 32'(4 * i)) begin
          errors++; $display("FAIL seq_order: issued=%h consumed=%h expected %h", issued_q[i], consumed_q[i], 4 * i);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    test_reset();
    set_knobs(100, 0, 100, 0);
    run(10);
    checks++; if (issued_q.size() != 2) begin errors++; $display("FAIL bp_issued: issued=%0d expected 2", issued_q.size()); end
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL bp_req: imem_req=%b expected 0", imem_req); end
    checks++; if (instr_valid !== 1'b1) begin errors++; $display("FAIL bp_valid: instr_valid=%b expected 1", instr_valid); end
    p_irdy = 100;
    run(6);
    checks++;
    if (issued_q.size() < 3 || issued_q[2] !== 32'h8) begin
      errors++; $display("FAIL bp_resume: issued=%0d third addr wrong, expected 00000008", issued_q.size());
    end
  endtask

  task automatic test_mid_reset();
    test_reset();
    set_knobs(100, 0, 100, 0);
    run(6);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if (instr_valid !== 1'b0 || imem_req !== 1'b0 || instr_pc_plus4 !== 32'h4) begin
      errors++; $display("FAIL mid_reset: valid=%b req=%b pc4=%h expected 0 0 00000004", instr_valid, imem_req, instr_pc_plus4);
    end
    clear_model();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_redirect_outstanding();
    bit d;
    int ni, nc;
    test_reset();
    set_knobs(100, 100, 100, 0);
    mem_hold = 1'b1;
    run(2);
    checks++; if (issued_q.size() != 2) begin errors++; $display("FAIL ro_issued: issued=%0d expected 2", issued_q.size()); end
    ni = issued_q.size(); nc = consumed_q.size();
    cycle(1, 32'h100, d);
    mem_hold = 1'b0;
    run(10);
    checks++;
    if (consumed_q.size() <= nc || consumed_q[nc] !== 32'h100) begin
      errors++; $display("FAIL ro_deliver: consumed=%0d first pc after redirect wrong, expected 00000100", consumed_q.size() - nc);
    end
    checks++;
    if (issued_q.size() <= ni || issued_q[ni] !== 32'h100) begin
      errors++; $display("FAIL ro_fetch: issued=%0d first addr after redirect wrong, expected 00000100", issued_q.size() - ni);
    end
  endtask

  task automatic test_redirect_coincident();
    bit d;
    int nc;
    test_reset();
    set_knobs(100, 100, 100, 0);
    d = 1'b0;
    for (int i = 0; i < 20 && !d; i++) cycle(2, 32'h240, d);
    checks++; if (d !== 1'b1) begin errors++; $display("FAIL coinc_setup: redirect=%b expected 1", d); end
    nc = consumed_q.size();
    run(8);
    checks++;
    if (consumed_q.size() <= nc || consumed_q[nc] !== 32'h240) begin
      errors++; $display("FAIL coinc_deliver: consumed=%0d first pc after redirect wrong, expected 00000240", consumed_q.size() - nc);
    end
  endtask

  task automatic test_wrap();
    bit d;
    int ni, nc;
    test_reset();
    set_knobs(100, 100, 100, 0);
    run(3);
    ni = issued_q.size(); nc = consumed_q.size();
    cycle(1, 32'hFFFF_FFFC, d);
    run(10);
    checks++;
    if (issued_q.size() < ni + 2 || issued_q[ni] !== 32'hFFFF_FFFC || issued_q[ni+1] !== 32'h0) begin
      errors++; $display("FAIL wrap_fetch: issued=%0d after redirect, expected fffffffc then 00000000", issued_q.size() - ni);
    end
    checks++;
    if (consumed_q.size() < nc + 2 || consumed_q[nc] !== 32'hFFFF_FFFC || consumed_q[nc+1] !== 32'h0) begin
      errors++; $display("FAIL wrap_deliver: consumed=%0d after redirect, expected fffffffc then 00000000", consumed_q.size() - nc);
    end
  endtask

`ifdef FETCH_MISALIGN_TRAP_EN
  task automatic test_misalign();
    bit d;
    int ni, nc;
    test_reset();
    set_knobs(100, 100, 100, 0);
    run(4);
    p_irdy = 0;
    cycle(1, 32'h102, d);
    ni = issued_q.size();
    run(5);
    checks++; if (issued_q.size() != ni) begin errors++; $display("FAIL trap_stall: issued=%0d expected 0 after trap", issued_q.size() - ni); end
    checks++;
    if (instr_valid !== 1'b1 || instr_fault !== 1'b1 || instr !== 32'h13 || instr_pc !== 32'h102) begin
      errors++; $display("FAIL trap_entry: valid=%b fault=%b instr=%h pc=%h expected 1 1 00000013 00000102",
                         instr_valid, instr_fault, instr, instr_pc);
    end
    cycle(1, 32'h200, d);
    p_irdy = 100;
    nc = consumed_q.size();
    run(8);
    checks++;
    if (consumed_q.size() <= nc || consumed_q[nc] !== 32'h200 || instr_fault !== 1'b0) begin
      errors++; $display("FAIL trap_resume: consumed=%0d fault=%b expected first pc 00000200 and fault 0", consumed_q.size() - nc, instr_fault);
    end
  endtask
`else
  task automatic test_misalign();
    bit d;
    int ni, nc;
    test_reset();
    set_knobs(100, 100, 100, 0);
    run(3);
    ni = issued_q.size(); nc = consumed_q.size();
    cycle(1, 32'h102, d);
    run(8);
    checks++;
    if (issued_q.size() <= ni || issued_q[ni] !== 32'h100) begin
      errors++; $display("FAIL misalign_fetch: issued=%0d first addr wrong, expected 00000100", issued_q.size() - ni);
    end
    checks++;
    if (consumed_q.size() <= nc || consumed_q[nc] !== 32'h100) begin
      errors++; $display("FAIL misalign_deliver: consumed=%0d first pc wrong, expected 00000100", consumed_q.size() - nc);
    end
  endtask
`endif

  task automatic test_random();
    bit d;
    logic [31:0] t;
    test_reset();
    set_knobs(70, 70, 80, 2);
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(99) < 4) begin
        case ($urandom_range(3))
          0:       t = $urandom & 32'h0000_0FFF;
          1:       t = 32'hFFFF_FFF0 + 32'($urandom_range(15));
          default: t = $urandom;
        endcase
`ifdef FETCH_MISALIGN_TRAP_EN
        t[1:0] = 2'b00;
`endif
        cycle(1, t, d);
      end else begin
        cycle(0, '0, d);
      end
    end
    checks++;
    if (consumed_q.size() < 100) begin
      errors++; $display("FAIL random_progress: consumed=%0d expected >=100", consumed_q.size());
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    checks = 0; errors = 0; cyc = 0;
    rst = 1'b1;
    imem_ready = 0; imem_rvalid = 0; imem_rdata = 0;
    redirect = 0; redirect_target = 0; instr_ready = 0;
    set_knobs(100, 100, 100, 0);
    clear_model();
    repeat (2) @(posedge clk);
    test_reset();
    test_sequential();
    test_backpressure();
    test_mid_reset();
    test_redirect_outstanding();
    test_redirect_coincident();
    test_wrap();
    test_misalign();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
